// File: rtl/mem_pkg.sv
// Shared types for the memory port arbiter: access sizes, arbiter states and
// requester identities.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_t;

  typedef enum logic {
    IDLE,
    RMW_WR
  } arb_state_t;

  typedef enum logic {
    PORT_IF,
    PORT_DATA
  } port_id_t;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for main memory: extracts and extends sub-word loads and
// merges sub-word store data into an existing word.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged,
  output logic        misaligned
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b     = word[{offset, 3'b000} +: 8];
    lane_h     = offset[1] ? word[31:16] : word[15:0];
    load_val   = word;
    merged     = word;
    misaligned = 1'b0;
    case (size)
      MEM_BYTE: begin
        load_val = {{24{~is_unsigned & lane_b[7]}}, lane_b};
        merged[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      MEM_HALF: begin
        load_val = {{16{~is_unsigned & lane_h[15]}}, lane_h};
        if (offset[1]) merged[31:16] = wdata[15:0];
        else           merged[15:0]  = wdata[15:0];
        misaligned = offset[0];
      end
      MEM_WORD: begin
        load_val   = word;
        merged     = wdata;
        misaligned = |offset;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store access to single-ported main memory; sub-word
// stores become a read cycle followed by a one-cycle merged write (RMW_WR).
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [31:0] i_d_addr,
  input  logic [1:0]  i_d_size,
  input  logic        i_d_unsigned,
  input  logic [31:0] i_d_wdata,
  output logic        o_d_gnt,
  output logic        o_d_rvalid,
  output logic [31:0] o_d_rdata,
  output logic        o_d_err,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_wr_en,
  output logic [31:0] o_mem_wr_val,
  input  logic [31:0] i_mem_val
);

  // Handshake: a requester holds req and its fields stable until it sees gnt
  // high in the same cycle; the transfer happens at that edge. Read data comes
  // back as a single-cycle rvalid (or d_err) pulse on the following cycle.

  arb_state_t  state;
  port_id_t    last_grant;
  logic [31:0] rmw_addr, rmw_word, rmw_wdata;
  logic [1:0]  rmw_size, rmw_off;

  logic        in_rmw, idle_ok, d_pick;
  logic [31:0] la_word, la_wdata, load_val, merged;
  logic [1:0]  la_off, la_size;
  logic        misaligned;

  assign in_rmw = (state == RMW_WR);

  // While writing back, the aligner merges the latched store instead of
  // looking at the live data port.
  always_comb begin
    la_word  = in_rmw ? rmw_word  : i_mem_val;
    la_wdata = in_rmw ? rmw_wdata : i_d_wdata;
    la_off   = in_rmw ? rmw_off   : i_d_addr[1:0];
    la_size  = in_rmw ? rmw_size  : i_d_size;
  end

  mem_lane_align u_align (
    .word        (la_word),
    .offset      (la_off),
    .size        (la_size),
    .is_unsigned (i_d_unsigned),
    .wdata       (la_wdata),
    .load_val    (load_val),
    .merged      (merged),
    .misaligned  (misaligned)
  );

  always_comb begin
    idle_ok = (state == IDLE) && !i_rst;
    if (ROUND_ROBIN != 0) d_pick = i_d_req && (!i_if_req || last_grant == PORT_IF);
    else                  d_pick = i_d_req;
    o_d_gnt  = idle_ok && d_pick;
    o_if_gnt = idle_ok && i_if_req && !d_pick;

    o_mem_addr   = 32'h0;
    o_mem_wr_en  = 1'b0;
    o_mem_wr_val = 32'h0;
    if (in_rmw && !i_rst) begin
      o_mem_addr   = rmw_addr;
      o_mem_wr_en  = 1'b1;
      o_mem_wr_val = merged;
    end else if (o_d_gnt) begin
      o_mem_addr = i_d_addr & WORD_MASK;
      if (i_d_we && !misaligned && i_d_size == MEM_WORD) begin
        o_mem_wr_en  = 1'b1;
        o_mem_wr_val = i_d_wdata;
      end
    end else if (o_if_gnt) begin
      o_mem_addr = i_if_addr & WORD_MASK;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      last_grant  <= PORT_DATA;
      o_if_rvalid <= 1'b0;
      o_if_rdata  <= 32'h0;
      o_d_rvalid  <= 1'b0;
      o_d_rdata   <= 32'h0;
      o_d_err     <= 1'b0;
      rmw_addr    <= 32'h0;
      rmw_word    <= 32'h0;
      rmw_wdata   <= 32'h0;
      rmw_size    <= 2'b00;
      rmw_off     <= 2'b00;
    end else begin
      o_if_rvalid <= 1'b0;
      o_d_rvalid  <= 1'b0;
      o_d_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (o_if_gnt) begin
            last_grant  <= PORT_IF;
            o_if_rvalid <= 1'b1;
            o_if_rdata  <= i_mem_val;
          end
          if (o_d_gnt) begin
            last_grant <= PORT_DATA;
            if (misaligned) begin
              o_d_err   <= 1'b1;
              o_d_rdata <= 32'h0;
            end else if (!i_d_we) begin
              o_d_rvalid <= 1'b1;
              o_d_rdata  <= load_val;
            end else if (i_d_size != MEM_WORD) begin
              rmw_addr  <= i_d_addr & WORD_MASK;
              rmw_word  <= i_mem_val;
              rmw_wdata <= i_d_wdata;
              rmw_size  <= i_d_size;
              rmw_off   <= i_d_addr[1:0];
              state     <= RMW_WR;
            end
          end
        end
        RMW_WR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: round-robin instance under full check,
// plus a fixed-priority instance for the contention scenario.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [1:0]  d_size = 2'b00;
  logic        d_unsigned = 1'b0;
  logic [31:0] d_wdata = '0;
  logic [31:0] mem_val = '0;

  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, wr_en;
  logic [31:0] if_rdata, d_rdata, mem_addr, wr_val;
  logic        if_gnt_p, if_rvalid_p, d_gnt_p, d_rvalid_p, d_err_p, wr_en_p;
  logic [31:0] if_rdata_p, d_rdata_p, mem_addr_p, wr_val_p;

  int errors = 0;
  int checks = 0;

  // clock/reset
  always #5 clk = ~clk;

  mem_port_arbiter #(.ROUND_ROBIN(1)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt),
    .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_size(d_size),
    .i_d_unsigned(d_unsigned), .i_d_wdata(d_wdata), .o_d_gnt(d_gnt),
    .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata), .o_d_err(d_err),
    .o_mem_addr(mem_addr), .o_mem_wr_en(wr_en), .o_mem_wr_val(wr_val),
    .i_mem_val(mem_val)
  );

  mem_port_arbiter #(.ROUND_ROBIN(0)) dut_fp (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt_p),
    .o_if_rvalid(if_rvalid_p), .o_if_rdata(if_rdata_p),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_size(d_size),
    .i_d_unsigned(d_unsigned), .i_d_wdata(d_wdata), .o_d_gnt(d_gnt_p),
    .o_d_rvalid(d_rvalid_p), .o_d_rdata(d_rdata_p), .o_d_err(d_err_p),
    .o_mem_addr(mem_addr_p), .o_mem_wr_en(wr_en_p), .o_mem_wr_val(wr_val_p),
    .i_mem_val(mem_val)
  );

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive_data(input logic we, input logic [31:0] addr, input logic [1:0] size,
                            input logic uns, input logic [31:0] wdata);
    d_req = 1'b1; d_we = we; d_addr = addr; d_size = size; d_unsigned = uns; d_wdata = wdata;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h100;
    drive_data(1'b0, 32'h200, MEM_WORD, 1'b0, 32'h0);
    #1;
    checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL rst_if_gnt got=%0h exp=0", if_gnt); end
    checks++; if (d_gnt !== 1'b0) begin errors++; $display("FAIL rst_d_gnt got=%0h exp=0", d_gnt); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got=%0h exp=0", wr_en); end
    @(negedge clk);
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
    #1;
    checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL rst_if_rvalid got=%0h exp=0", if_rvalid); end
    checks++; if (if_rdata !== 32'h0) begin errors++; $display("FAIL rst_if_rdata got=%h exp=0", if_rdata); end
    checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL rst_d_rvalid got=%0h exp=0", d_rvalid); end
    checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL rst_d_rdata got=%h exp=0", d_rdata); end
    checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL rst_d_err got=%0h exp=0", d_err); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL idle_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (if_gnt !== 1'b0 || d_gnt !== 1'b0) begin errors++; $display("FAIL idle_gnt got=%0h%0h exp=00", if_gnt, d_gnt); end
  endtask

  task automatic test_fetch();
    do_reset();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0104; mem_val = 32'hDEAD_BEEF;
    #1;
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL fetch_gnt got=%0h exp=1", if_gnt); end
    checks++; if (d_gnt !== 1'b0) begin errors++; $display("FAIL fetch_d_gnt got=%0h exp=0", d_gnt); end
    checks++; if (mem_addr !== 32'h104) begin errors++; $display("FAIL fetch_addr got=%h exp=00000104", mem_addr); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL fetch_wr_en got=%0h exp=0", wr_en); end
    @(negedge clk);
    if_req = 1'b0;
    #1;
    checks++; if (if_rvalid !== 1'b1) begin errors++; $display("FAIL fetch_rvalid got=%0h exp=1", if_rvalid); end
    checks++; if (if_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fetch_rdata got=%h exp=deadbeef", if_rdata); end
    checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_d_rvalid got=%0h exp=0", d_rvalid); end
    @(negedge clk); #1;
    checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_rvalid_pulse got=%0h exp=0", if_rvalid); end
  endtask

  task automatic test_arbitration();
    do_reset();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h300; mem_val = 32'h1234_5678;
    drive_data(1'b0, 32'h400, MEM_WORD, 1'b0, 32'h0);
    #1;
    checks++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL rr_first got=if%0h/d%0h exp=if1/d0", if_gnt, d_gnt); end
    checks++; if (mem_addr !== 32'h300) begin errors++; $display("FAIL rr_first_addr got=%h exp=00000300", mem_addr); end
    checks++; if (d_gnt_p !== 1'b1 || if_gnt_p !== 1'b0) begin errors++; $display("FAIL fp_first got=if%0h/d%0h exp=if0/d1", if_gnt_p, d_gnt_p); end
    checks++; if (mem_addr_p !== 32'h400) begin errors++; $display("FAIL fp_first_addr got=%h exp=00000400", mem_addr_p); end
    @(negedge clk);
    #1;
    checks++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin errors++; $display("FAIL rr_second got=if%0h/d%0h exp=if0/d1", if_gnt, d_gnt); end
    checks++; if (mem_addr !== 32'h400) begin errors++; $display("FAIL rr_second_addr got=%h exp=00000400", mem_addr); end
    checks++; if (if_rvalid !== 1'b1) begin errors++; $display("FAIL rr_if_rvalid got=%0h exp=1", if_rvalid); end
    checks++; if (d_gnt_p !== 1'b1 || if_gnt_p !== 1'b0) begin errors++; $display("FAIL fp_second got=if%0h/d%0h exp=if0/d1", if_gnt_p, d_gnt_p); end
    checks++; if (d_rvalid_p !== 1'b1) begin errors++; $display("FAIL fp_d_rvalid got=%0h exp=1", d_rvalid_p); end
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    #1;
    checks++; if (d_rvalid !== 1'b1) begin errors++; $display("FAIL rr_d_rvalid got=%0h exp=1", d_rvalid); end
    checks++; if (d_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rr_d_rdata got=%h exp=12345678", d_rdata); end
  endtask

  task automatic test_load_ext();
    logic [31:0] addr_t[5];
    logic [1:0]  size_t[5];
    logic        uns_t[5];
    logic [31:0] exp_t[5];
    addr_t = '{32'h203, 32'h203, 32'h202, 32'h200, 32'h202};
    size_t = '{MEM_BYTE, MEM_BYTE, MEM_HALF, MEM_HALF, MEM_BYTE};
    uns_t  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_t  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_0011, 32'hFFFF_FFFF};
    mem_val = 32'h80FF_0011;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== exp_t[i-1]) begin errors++; $display("FAIL load_%0d got=v%0h/%h exp=v1/%h", i-1, d_rvalid, d_rdata, exp_t[i-1]); end
      end
      if (i < 5) begin
        drive_data(1'b0, addr_t[i], size_t[i], uns_t[i], 32'h0);
        #1;
        checks++; if (d_gnt !== 1'b1 || mem_addr !== 32'h200) begin errors++; $display("FAIL load_gnt_%0d got=g%0h/%h exp=g1/00000200", i, d_gnt, mem_addr); end
      end else begin
        d_req = 1'b0;
      end
    end
  endtask

  task automatic test_store();
    @(negedge clk);
    mem_val = 32'h1122_3344;
    drive_data(1'b1, 32'h101, MEM_BYTE, 1'b0, 32'hFFFF_FFAB);
    #1;
    checks++; if (d_gnt !== 1'b1 || wr_en !== 1'b0) begin errors++; $display("FAIL sb_gnt got=g%0h/w%0h exp=g1/w0", d_gnt, wr_en); end
    checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL sb_addr got=%h exp=00000100", mem_addr); end
    @(negedge clk);
    d_req = 1'b0; if_req = 1'b1; if_addr = 32'h500; mem_val = 32'hFFFF_FFFF;
    #1;
    checks++; if (wr_en !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL sb_rmw got=w%0h/%h exp=w1/00000100", wr_en, mem_addr); end
    checks++; if (wr_val !== 32'h1122_AB44) begin errors++; $display("FAIL sb_merge got=%h exp=1122ab44", wr_val); end
    checks++; if (if_gnt !== 1'b0 || d_gnt !== 1'b0) begin errors++; $display("FAIL sb_rmw_gnt got=if%0h/d%0h exp=00", if_gnt, d_gnt); end
    checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL sb_rvalid got=%0h exp=0", d_rvalid); end
    @(negedge clk);
    #1;
    checks++; if (if_gnt !== 1'b1 || mem_addr !== 32'h500 || wr_en !== 1'b0) begin errors++; $display("FAIL sb_held_fetch got=g%0h/%h/w%0h exp=g1/00000500/w0", if_gnt, mem_addr, wr_en); end
    @(negedge clk);
    if_req = 1'b0; mem_val = 32'h1122_3344;
    drive_data(1'b1, 32'h102, MEM_HALF, 1'b0, 32'h1234_BEEF);
    #1;
    checks++; if (d_gnt !== 1'b1 || wr_en !== 1'b0) begin errors++; $display("FAIL sh_gnt got=g%0h/w%0h exp=g1/w0", d_gnt, wr_en); end
    @(negedge clk);
    d_req = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b1 || wr_val !== 32'hBEEF_3344 || mem_addr !== 32'h100) begin errors++; $display("FAIL sh_merge got=w%0h/%h/%h exp=w1/beef3344/00000100", wr_en, wr_val, mem_addr); end
    @(negedge clk);
    drive_data(1'b1, 32'h200, MEM_WORD, 1'b0, 32'hCAFE_F00D);
    #1;
    checks++; if (d_gnt !== 1'b1 || wr_en !== 1'b1) begin errors++; $display("FAIL sw_gnt got=g%0h/w%0h exp=g1/w1", d_gnt, wr_en); end
    checks++; if (wr_val !== 32'hCAFE_F00D || mem_addr !== 32'h200) begin errors++; $display("FAIL sw_data got=%h/%h exp=cafef00d/00000200", wr_val, mem_addr); end
    @(negedge clk);
    d_req = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0 || d_rvalid !== 1'b0 || d_err !== 1'b0) begin errors++; $display("FAIL sw_after got=w%0h/v%0h/e%0h exp=000", wr_en, d_rvalid, d_err); end
  endtask

  task automatic test_error();
    @(negedge clk);
    drive_data(1'b1, 32'h102, MEM_WORD, 1'b0, 32'h5555_AAAA);
    #1;
    checks++; if (d_gnt !== 1'b1 || wr_en !== 1'b0) begin errors++; $display("FAIL err_sw_gnt got=g%0h/w%0h exp=g1/w0", d_gnt, wr_en); end
    @(negedge clk);
    drive_data(1'b0, 32'h200, 2'b11, 1'b0, 32'h0);
    #1;
    checks++; if (d_err !== 1'b1 || d_rdata !== 32'h0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL err_sw_pulse got=e%0h/%h/v%0h exp=e1/0/v0", d_err, d_rdata, d_rvalid); end
    checks++; if (d_gnt !== 1'b1 || wr_en !== 1'b0) begin errors++; $display("FAIL err_size_gnt got=g%0h/w%0h exp=g1/w0", d_gnt, wr_en); end
    @(negedge clk);
    drive_data(1'b0, 32'h201, MEM_HALF, 1'b0, 32'h0);
    #1;
    checks++; if (d_err !== 1'b1) begin errors++; $display("FAIL err_size_pulse got=%0h exp=1", d_err); end
    @(negedge clk);
    d_req = 1'b0; if_req = 1'b1; if_addr = 32'h507;
    #1;
    checks++; if (d_err !== 1'b1 || d_rvalid !== 1'b0) begin errors++; $display("FAIL err_half_pulse got=e%0h/v%0h exp=e1/v0", d_err, d_rvalid); end
    checks++; if (if_gnt !== 1'b1 || mem_addr !== 32'h504) begin errors++; $display("FAIL fetch_unaligned got=g%0h/%h exp=g1/00000504", if_gnt, mem_addr); end
    @(negedge clk);
    if_req = 1'b0;
    #1;
    checks++; if (d_err !== 1'b0 || if_rvalid !== 1'b1) begin errors++; $display("FAIL fetch_no_err got=e%0h/v%0h exp=e0/v1", d_err, if_rvalid); end
  endtask

  task automatic test_reset_rmw();
    @(negedge clk);
    mem_val = 32'h1122_3344;
    drive_data(1'b1, 32'h101, MEM_BYTE, 1'b0, 32'h0000_00AB);
    #1;
    checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL rrmw_gnt got=%0h exp=1", d_gnt); end
    @(negedge clk);
    d_req = 1'b0; rst = 1'b1;
    #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rrmw_dropped got=%0h exp=0", wr_en); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL rrmw_mem got=w%0h/%h exp=w0/0", wr_en, mem_addr); end
    checks++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || d_err !== 1'b0) begin errors++; $display("FAIL rrmw_pulses got=%0h%0h%0h exp=000", if_rvalid, d_rvalid, d_err); end
    checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL rrmw_rdata got=%h/%h exp=0/0", if_rdata, d_rdata); end
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    checks++; if (if_gnt !== 1'b1 || wr_en !== 1'b0) begin errors++; $display("FAIL rrmw_idle got=g%0h/w%0h exp=g1/w0", if_gnt, wr_en); end
    @(negedge clk);
    if_req = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_fetch();
    test_arbitration();
    test_load_ext();
    test_store();
    test_error();
    test_reset_rmw();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
